// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared TS constants, scheduler state type and null packet byte generator
package ts_pkg;

   localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
   localparam int          TS_PKT_LEN   = 188;
   localparam logic [12:0] NULL_PID     = 13'h1FFF;
   localparam logic [2:0]  SRC_NULL     = 3'd4;

   typedef enum logic [1:0] {ARB, READ, NULL, GAP} sched_state_t;

   // Null packet: sync, PID 0x1FFF, payload-only with CC=0, then 0xFF stuffing.
   function automatic logic [7:0] null_byte(input int unsigned idx);
      case (idx)
         0:       null_byte = TS_SYNC_BYTE;
         1:       null_byte = {3'b000, NULL_PID[12:8]};
         2:       null_byte = NULL_PID[7:0];
         3:       null_byte = 8'h10;
         default: null_byte = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin arbiter, search starts after the last grant
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [3:0] grant,
   output logic [1:0] idx,
   output logic       valid
);

   logic [1:0] cand;

   always_comb begin
      grant = 4'b0000;
      idx   = last;
      valid = 1'b0;
      cand  = last;
      // i = 4 wraps back to last itself, so it is considered last.
      for (int i = 1; i <= 4; i++) begin
         cand = last + 2'(i);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
            grant = 4'b0001 << cand;
         end
      end
   end

endmodule

// File: rtl/ts_packet_scheduler.sv
// rtl/ts_packet_scheduler.sv - packet-level round-robin scheduler for the 4-input TS mux
module ts_packet_scheduler
   import ts_pkg::*;
#(
   parameter int PKT_LEN    = TS_PKT_LEN,
   parameter int GAP_CYCLES = 0,
   parameter int N_SRC      = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  GOT_FULL_PACKET,
   input  logic [31:0] DATA_IN_BUS,
   input  logic [3:0]  ENABLE,
   input  logic        NULL_ENA,
   output logic [3:0]  RD_REQ,
   output logic [7:0]  DATA_OUT,
   output logic        D_VALID_OUT,
   output logic        P_SYNC_OUT,
   output logic [2:0]  SRC_SEL,
   output logic        SYNC_ERR,
   output logic        BUSY
);

   localparam int SEL_W = $clog2(N_SRC);
   localparam int CNT_W = $clog2(PKT_LEN);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   sched_state_t     state;
   logic [CNT_W-1:0] byte_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [SEL_W-1:0] sel;
   logic [SEL_W-1:0] last_sel;

   logic [3:0]       arb_grant;
   logic [1:0]       arb_idx;
   logic             arb_valid;

   logic             s1_valid;
   logic             s1_first;
   logic             s1_null;
   logic [SEL_W-1:0] s1_sel;
   logic [7:0]       s1_null_byte;
   logic [7:0]       src_byte;

   rr_arbiter4 u_arb (
      .req   (GOT_FULL_PACKET & ENABLE),
      .last  (last_sel),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign BUSY     = (state != ARB);
   assign src_byte = DATA_IN_BUS[{s1_sel, 3'b000} +: 8];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= ARB;
         byte_cnt <= '0;
         gap_cnt  <= '0;
         sel      <= '0;
         last_sel <= SEL_W'(3);
         RD_REQ   <= 4'b0000;
      end else begin
         case (state)
            ARB: begin
               byte_cnt <= '0;
               if (arb_valid) begin
                  sel      <= arb_idx;
                  last_sel <= arb_idx;
                  RD_REQ   <= arb_grant;
                  state    <= READ;
               end else if (NULL_ENA) begin
                  state <= NULL;
               end
            end
            READ, NULL: begin
               if (byte_cnt == CNT_LAST) begin
                  byte_cnt <= '0;
                  RD_REQ   <= 4'b0000;
                  state    <= (GAP_CYCLES == 0) ? ARB : GAP;
               end else begin
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  state   <= ARB;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   // Stage 1 lines up with the cycle the FIFO presents the byte requested one cycle earlier.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1_valid     <= 1'b0;
         s1_first     <= 1'b0;
         s1_null      <= 1'b0;
         s1_sel       <= '0;
         s1_null_byte <= 8'h00;
         DATA_OUT     <= 8'h00;
         D_VALID_OUT  <= 1'b0;
         P_SYNC_OUT   <= 1'b0;
         SRC_SEL      <= 3'd0;
         SYNC_ERR     <= 1'b0;
      end else begin
         s1_valid     <= (state == READ) || (state == NULL);
         s1_first     <= (byte_cnt == '0);
         s1_null      <= (state == NULL);
         s1_sel       <= sel;
         s1_null_byte <= null_byte(32'(byte_cnt));

         D_VALID_OUT  <= s1_valid;
         P_SYNC_OUT   <= s1_valid && s1_first;
         SYNC_ERR     <= s1_valid && s1_first && !s1_null && (src_byte != TS_SYNC_BYTE);
         if (s1_valid) begin
            DATA_OUT <= s1_null ? s1_null_byte : src_byte;
            SRC_SEL  <= s1_null ? SRC_NULL : 3'(s1_sel);
         end
      end
   end

endmodule
